// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared encodings for the E-stage MDU issue controller: the E-stage
//            instruction class, the MDU op codes and the controller state enum.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  // E-stage MDU instruction class; codes above EOP_MFLO behave as EOP_NONE
  typedef enum logic [3:0] {
    EOP_NONE  = 4'd0,
    EOP_MULTU = 4'd1,
    EOP_MULT  = 4'd2,
    EOP_DIVU  = 4'd3,
    EOP_DIV   = 4'd4,
    EOP_MTHI  = 4'd5,
    EOP_MTLO  = 4'd6,
    EOP_MFHI  = 4'd7,
    EOP_MFLO  = 4'd8
  } e_op_t;

  // Op codes understood by the MDU itself
  localparam logic [2:0] c_mdu_multu = 3'b000;
  localparam logic [2:0] c_mdu_mult  = 3'b001;
  localparam logic [2:0] c_mdu_divu  = 3'b010;
  localparam logic [2:0] c_mdu_div   = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_MF_DONE = 2'd2
  } state_t;

  // True for the four instructions that start a multiply or divide
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op >= EOP_MULTU) && (op <= EOP_DIV);
  endfunction

  // True for any defined class other than NONE
  function automatic logic is_known(input logic [3:0] op);
    return (op != EOP_NONE) && (op <= EOP_MFLO);
  endfunction

  // Instruction class to MDU op code
  function automatic logic [2:0] mdu_op_of(input logic [3:0] op);
    case (op)
      EOP_MULT: return c_mdu_mult;
      EOP_DIVU: return c_mdu_divu;
      EOP_DIV:  return c_mdu_div;
      default:  return c_mdu_multu;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : mdu_watchdog
// Purpose  : Saturating busy-cycle counter with a sticky error flag that sets
//            on the edge where the count reaches MAX_LAT.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_watchdog #(
  parameter int MAX_LAT = 12,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic err
);

  localparam logic [CNT_W-1:0] c_limit = CNT_W'(MAX_LAT);

  logic [CNT_W-1:0] r_count;
  logic             r_err;

  // Count busy cycles since the last start; flag is held until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (clear) begin
        r_count <= '0;
      end else if (tick && (r_count != c_limit)) begin
        r_count <= r_count + 1'b1;
      end
      if (!clear && tick && (r_count == (c_limit - 1'b1))) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;

endmodule
`default_nettype wire

// File: rtl/mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_issue_ctrl
// Purpose  : E-stage issue controller in front of the multiply/divide unit.
//            Issues starts and HI/LO writes, stalls E on structural and HI/LO
//            hazards, returns MFHI/MFLO through a registered read path and
//            watches for an MDU that never drops busy.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MAX_LAT = 12,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              e_valid,
  input  logic [3:0]        e_op,
  input  logic [DATA_W-1:0] e_rs,
  input  logic [DATA_W-1:0] e_rt,
  input  logic              e_flush,
  input  logic              mdu_busy,
  input  logic [DATA_W-1:0] mdu_hi,
  input  logic [DATA_W-1:0] mdu_lo,
  output logic              mdu_start,
  output logic [2:0]        mdu_op,
  output logic              mdu_hiwe,
  output logic              mdu_lowe,
  output logic [DATA_W-1:0] mdu_in1,
  output logic [DATA_W-1:0] mdu_in2,
  output logic              stall_e,
  output logic              mf_valid,
  output logic [DATA_W-1:0] mf_result,
  output logic              err_timeout
);

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_mf_q;

  logic       w_act;
  logic       w_is_mf;
  logic       w_start;
  logic [2:0] w_op;
  logic       w_hiwe;
  logic       w_lowe;
  logic       w_stall;
  logic       w_mfv;

  assign w_act   = e_valid & ~e_flush;
  assign w_is_mf = (e_op == EOP_MFHI) || (e_op == EOP_MFLO);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture HI or LO when an MF read is accepted in IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mf_q <= '0;
    end else if ((r_state == ST_IDLE) && w_act && (e_op == EOP_MFHI)) begin
      r_mf_q <= mdu_hi;
    end else if ((r_state == ST_IDLE) && w_act && (e_op == EOP_MFLO)) begin
      r_mf_q <= mdu_lo;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_act && is_muldiv(e_op)) begin
          w_next_state = ST_BUSY;
        end else if (w_act && w_is_mf) begin
          w_next_state = ST_MF_DONE;
        end
      end
      ST_BUSY: begin
        // A flush never aborts the MDU; only busy falling ends BUSY
        if (!mdu_busy) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_MF_DONE: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Strobes and stall from state and the E-stage instruction
  always_comb begin
    w_start = 1'b0;
    w_op    = c_mdu_multu;
    w_hiwe  = 1'b0;
    w_lowe  = 1'b0;
    w_stall = 1'b0;
    w_mfv   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_start = w_act & is_muldiv(e_op);
        w_op    = w_start ? mdu_op_of(e_op) : c_mdu_multu;
        w_hiwe  = w_act & (e_op == EOP_MTHI);
        w_lowe  = w_act & (e_op == EOP_MTLO);
        // MF needs one cycle to read HI/LO into the result register
        w_stall = w_act & w_is_mf;
      end
      ST_BUSY: begin
        // Anything but NONE waits for the MDU, including a new mul/div
        w_stall = w_act & is_known(e_op);
      end
      ST_MF_DONE: begin
        w_mfv = ~e_flush;
      end
      default: begin
        w_stall = 1'b0;
      end
    endcase
  end

  // Reset also masks the combinational outputs so nothing leaks while held
  assign mdu_start = w_start & reset;
  assign mdu_op    = reset ? w_op : c_mdu_multu;
  assign mdu_hiwe  = w_hiwe & reset;
  assign mdu_lowe  = w_lowe & reset;
  assign stall_e   = w_stall & reset;
  assign mf_valid  = w_mfv & reset;
  assign mf_result = r_mf_q;
  assign mdu_in1   = e_rs;
  assign mdu_in2   = e_rt;

  mdu_watchdog #(
    .MAX_LAT (MAX_LAT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clear (w_start),
    .tick  ((r_state == ST_BUSY) && mdu_busy),
    .err   (err_timeout)
  );

endmodule
`default_nettype wire

// File: tb/tb_mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_issue_ctrl
// Purpose  : Scoreboard bench for mdu_issue_ctrl with a behavioural MDU and a
//            pipeline-level reference model of the issue rules.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mdu_issue_ctrl;
  import mdu_pkg::*;

  localparam int MAX_LAT = 12;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        e_valid = 1'b0;
  logic [3:0]  e_op = 4'd0;
  logic [31:0] e_rs = '0;
  logic [31:0] e_rt = '0;
  logic        e_flush = 1'b0;
  logic        mdu_busy;
  logic [31:0] mdu_hi, mdu_lo;
  logic        mdu_start, mdu_hiwe, mdu_lowe, stall_e, mf_valid, err_timeout;
  logic [2:0]  mdu_op;
  logic [31:0] mdu_in1, mdu_in2, mf_result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu_issue_ctrl #(.DATA_W(32), .MAX_LAT(MAX_LAT), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_op(e_op), .e_rs(e_rs),
    .e_rt(e_rt), .e_flush(e_flush), .mdu_busy(mdu_busy), .mdu_hi(mdu_hi),
    .mdu_lo(mdu_lo), .mdu_start(mdu_start), .mdu_op(mdu_op), .mdu_hiwe(mdu_hiwe),
    .mdu_lowe(mdu_lowe), .mdu_in1(mdu_in1), .mdu_in2(mdu_in2), .stall_e(stall_e),
    .mf_valid(mf_valid), .mf_result(mf_result), .err_timeout(err_timeout)
  );

  // Arithmetic result {hi, lo} of an MDU op
  function automatic logic [63:0] compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'b000: p = ua * ub;
      3'b001: p = sa * sb;
      3'b010: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin uq = ua / ub; ur = ua % ub; p = {ur[31:0], uq[31:0]}; end
      end
      3'b011: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin sq = sa / sb; sr = sa % sb; p = {sr[31:0], sq[31:0]}; end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  function automatic logic [2:0] bench_op(input logic [3:0] op);
    return (op == 4'd1) ? 3'b000 : (op == 4'd2) ? 3'b001 : (op == 4'd3) ? 3'b010 : 3'b011;
  endfunction

  // Behavioural MDU: busy for a fixed latency, HI/LO updated when busy ends
  int          b_cnt;
  logic        force_busy = 1'b0;
  logic [31:0] b_hi, b_lo, p_hi, p_lo;
  assign mdu_busy = (b_cnt != 0) || force_busy;
  assign mdu_hi   = b_hi;
  assign mdu_lo   = b_lo;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_cnt <= 0; b_hi <= '0; b_lo <= '0; p_hi <= '0; p_lo <= '0;
    end else begin
      if (mdu_start) begin
        b_cnt <= mdu_op[1] ? DIV_LAT : MUL_LAT;
        {p_hi, p_lo} <= compute(mdu_op, mdu_in1, mdu_in2);
      end else if (b_cnt != 0) begin
        b_cnt <= b_cnt - 1;
        if (b_cnt == 1) begin b_hi <= p_hi; b_lo <= p_lo; end
      end
      if (mdu_hiwe) b_hi <= mdu_in1;
      if (mdu_lowe) b_lo <= mdu_in1;
    end
  end

  // Scoreboard queues
  typedef struct { bit stall; bit start; bit hiwe; bit lowe; bit mfv; bit err; } ctl_t;
  typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; } start_t;
  ctl_t        ctl_q[$];
  start_t      start_q[$];
  logic [31:0] mf_q[$];

  // Reference model: architectural HI/LO plus pipeline occupancy
  bit          m_occ = 0, m_mf_pend = 0, m_err = 0, m_stall = 0;
  int          m_wd = 0;
  logic [31:0] m_mf_val = '0, ref_hi = '0, ref_lo = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One E-stage cycle: drive inputs, predict outputs, push expectations
  task automatic drive_cycle(input bit v, input bit f, input logic [3:0] op,
                             input logic [31:0] rs, input logic [31:0] rt);
    ctl_t c;
    start_t s;
    bit act, known;
    @(posedge clk); #1;
    e_valid = v; e_flush = f; e_op = op; e_rs = rs; e_rt = rt;
    act   = v && !f;
    known = (op >= 4'd1) && (op <= 4'd8);
    c = '{default: 0};
    c.err = m_err;
    if (m_mf_pend) begin
      c.mfv = !f;
      if (!f) mf_q.push_back(m_mf_val);
      m_mf_pend = 0;
    end else if (m_occ) begin
      c.stall = act && known;
      if (mdu_busy) begin
        if (m_wd < MAX_LAT) m_wd++;
        if (m_wd == MAX_LAT) m_err = 1;
      end else begin
        m_occ = 0;
      end
    end else if (act) begin
      if (op >= 4'd1 && op <= 4'd4) begin
        c.start = 1;
        s.op = bench_op(op); s.a = rs; s.b = rt;
        start_q.push_back(s);
        {ref_hi, ref_lo} = compute(s.op, rs, rt);
        m_occ = 1; m_wd = 0;
      end else if (op == 4'd5) begin
        c.hiwe = 1; ref_hi = rs;
      end else if (op == 4'd6) begin
        c.lowe = 1; ref_lo = rs;
      end else if (op == 4'd7 || op == 4'd8) begin
        c.stall = 1; m_mf_pend = 1;
        m_mf_val = (op == 4'd7) ? ref_hi : ref_lo;
      end
    end
    m_stall = c.stall;
    ctl_q.push_back(c);
    #1;
  endtask

  // Present an instruction and hold it while the model says it is stalled
  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, output int dut_stalls);
    int n;
    n = 0; dut_stalls = 0;
    drive_cycle(1'b1, 1'b0, op, rs, rt);
    if (stall_e) dut_stalls++;
    while (m_stall) begin
      n++;
      if (n > 40) begin
        checks++; errors++;
        $display("FAIL issue_bound: op %0d still held after %0d cycles, required release", op, n);
        break;
      end
      drive_cycle(1'b1, 1'b0, op, rs, rt);
      if (stall_e) dut_stalls++;
    end
  endtask

  // Assert reset with a live MULT in E; outputs must be zero at once
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; e_valid = 1'b1; e_flush = 1'b0; e_op = 4'd2; e_rs = 32'h5; e_rt = 32'h7;
    #1;
    chk("rst_start", mdu_start, 0);
    chk("rst_op", mdu_op, 0);
    chk("rst_hiwe", mdu_hiwe, 0);
    chk("rst_lowe", mdu_lowe, 0);
    chk("rst_stall", stall_e, 0);
    chk("rst_mfv", mf_valid, 0);
    chk("rst_mfres", mf_result, 0);
    chk("rst_err", err_timeout, 0);
    repeat (2) @(posedge clk);
    m_occ = 0; m_mf_pend = 0; m_err = 0; m_stall = 0; m_wd = 0; ref_hi = '0; ref_lo = '0;
    #1;
    reset = 1'b1; e_valid = 1'b0;
  endtask

  // Monitor: per-cycle control check, payload check whenever DUT presents one
  initial begin
    ctl_t c;
    start_t s;
    logic [31:0] v;
    forever begin
      @(negedge clk);
      if (ctl_q.size() > 0) begin
        c = ctl_q.pop_front();
        chk("stall_e", stall_e, c.stall);
        chk("mdu_start", mdu_start, c.start);
        chk("mdu_hiwe", mdu_hiwe, c.hiwe);
        chk("mdu_lowe", mdu_lowe, c.lowe);
        chk("mf_valid", mf_valid, c.mfv);
        chk("err_timeout", err_timeout, c.err);
        if (mdu_start) begin
          if (start_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL start_event: got unexpected start, required none");
          end else begin
            s = start_q.pop_front();
            chk("start_op", mdu_op, s.op);
            chk("start_in1", mdu_in1, s.a);
            chk("start_in2", mdu_in2, s.b);
          end
        end
        if (mf_valid) begin
          if (mf_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mf_event: got unexpected mf_valid, required none");
          end else begin
            v = mf_q.pop_front();
            chk("mf_result", mf_result, v);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int st;
    logic [3:0]  r_op;
    logic [31:0] r_rs, r_rt;
    bit v, f;

    do_reset();

    // Multiply then read LO
    issue(4'd2, 32'hFFFF_FFFE, 32'd3, st);
    chk("mult_start", mdu_start, 1);
    chk("mult_op", mdu_op, 3'b001);
    chk("mult_nostall", stall_e, 0);
    issue(4'd8, 32'd0, 32'd0, st);
    chk("mflo_valid", mf_valid, 1);
    chk("mflo_value", mf_result, 32'hFFFF_FFFA);

    // MTHI then MFHI
    issue(4'd5, 32'h1234_5678, 32'd0, st);
    chk("mthi_we", mdu_hiwe, 1);
    chk("mthi_nostall", stall_e, 0);
    issue(4'd7, 32'd0, 32'd0, st);
    chk("mfhi_stalls", st, 1);
    chk("mfhi_valid", mf_valid, 1);
    chk("mfhi_value", mf_result, 32'h1234_5678);

    // DIV then DIVU back-to-back: held through all busy cycles plus the fall
    issue(4'd4, 32'hFFFF_FF9C, 32'd7, st);
    issue(4'd3, 32'd50, 32'd3, st);
    chk("divu_stalls", st, DIV_LAT + 1);
    chk("divu_start", mdu_start, 1);
    chk("divu_op", mdu_op, 3'b010);
    repeat (DIV_LAT + 2) drive_cycle(1'b0, 1'b0, 4'd0, '0, '0);

    // Flushed MF in MF_DONE, then a flushed MULT in IDLE
    drive_cycle(1'b1, 1'b0, 4'd8, '0, '0);
    drive_cycle(1'b1, 1'b1, 4'd8, '0, '0);
    chk("flush_mfv", mf_valid, 0);
    drive_cycle(1'b1, 1'b1, 4'd2, 32'd9, 32'd9);
    chk("flush_start", mdu_start, 0);
    issue(4'd6, 32'hCAFE_0001, 32'd0, st);
    chk("mtlo_after_flush", mdu_lowe, 1);

    // Reset mid-BUSY, then a MULT issues immediately
    issue(4'd4, 32'd1000, 32'd3, st);
    repeat (3) drive_cycle(1'b0, 1'b0, 4'd0, '0, '0);
    do_reset();
    issue(4'd2, 32'd6, 32'd7, st);
    chk("post_rst_start", mdu_start, 1);
    chk("post_rst_stall", stall_e, 0);
    repeat (MUL_LAT + 2) drive_cycle(1'b0, 1'b0, 4'd0, '0, '0);

    // Watchdog: MDU stuck busy
    force_busy = 1'b1;
    issue(4'd1, 32'd3, 32'd4, st);
    repeat (20) drive_cycle(1'b1, 1'b0, 4'd0, '0, '0);
    chk("wd_err_set", err_timeout, 1);
    force_busy = 1'b0;
    repeat (4) drive_cycle(1'b0, 1'b0, 4'd0, '0, '0);
    chk("wd_err_sticky", err_timeout, 1);
    do_reset();

    // Randomized traffic; stalled instructions are held until released
    r_op = 4'd0; r_rs = '0; r_rt = '0;
    for (int i = 0; i < 500; i++) begin
      if (!m_stall) begin
        r_op = 4'($urandom_range(0, 10));
        r_rs = $urandom;
        r_rt = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
      end
      v = ($urandom_range(0, 7) != 0);
      f = ($urandom_range(0, 9) == 0);
      drive_cycle(v, f, r_op, r_rs, r_rt);
    end
    repeat (DIV_LAT + 3) drive_cycle(1'b0, 1'b0, 4'd0, '0, '0);

    @(negedge clk); #1;
    chk("start_q_drained", start_q.size(), 0);
    chk("mf_q_drained", mf_q.size(), 0);
    chk("ctl_q_drained", ctl_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
